// File: rtl/lcd_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_text_writer
// Description : Character-buffered writer for a 2x16 HD44780-style text LCD.
//               Holds a 32-byte screen buffer that can be written at any time.
//               Powers up and initialises the panel, then refreshes both lines
//               from the buffer forever.
//               Optional macro LCD_SNAPSHOT_EN adds a shadow buffer. The live
//               buffer is copied into it at the start of every frame, so each
//               frame shows one coherent set of characters.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_text_writer #(
  parameter int PHASE_CYC      = 10,
  parameter int WAIT_CYC       = 100,
  parameter int POWERUP_CYC    = 15000,
  parameter int CLEAR_WAIT_CYC = 2000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [4:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  output logic       READY,
  output logic       FRAME_DONE,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  // Byte slot: setup + E-high + hold phases, then the command execution wait.
  localparam int BYTE_LEN = 3 * PHASE_CYC + WAIT_CYC;
  localparam int CLR_LEN  = BYTE_LEN + CLEAR_WAIT_CYC;
  localparam int CNT_MAX  = (POWERUP_CYC > CLR_LEN) ? POWERUP_CYC : CLR_LEN;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_LEN - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_LEN - 1);
  localparam logic [CNT_W-1:0] E_FIRST   = CNT_W'(PHASE_CYC);
  localparam logic [CNT_W-1:0] E_LAST    = CNT_W'(2 * PHASE_CYC - 1);

  typedef enum logic [2:0] {
    S_PWR   = 3'd0,
    S_INIT  = 3'd1,
    S_ADDR1 = 3'd2,
    S_LINE1 = 3'd3,
    S_ADDR2 = 3'd4,
    S_LINE2 = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, slot_last;
  logic [3:0]       idx, idx_nxt;
  logic             latch;
  logic             rs_nxt, e_nxt, done_nxt;
  logic [7:0]       data_nxt, line_byte;
  logic [4:0]       rd_addr;
  logic [7:0]       mem [32];

  assign LCD_RW = 1'b0;

  // Live screen buffer: reset to spaces, written whenever the strobe is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
    end else if (WR_EN) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

`ifdef LCD_SNAPSHOT_EN
  logic [7:0] shadow [32];

  // Shadow copy taken on the edge that enters ADDR1; a write on that same edge
  // reaches only the live buffer (the copy sees the pre-write contents).
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
    end else if (latch && state_nxt == S_ADDR1) begin
      for (int i = 0; i < 32; i++) shadow[i] <= mem[i];
    end
  end
`endif

  // Sequencer next state, byte selection and strobe timing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    latch     = 1'b0;
    rs_nxt    = LCD_RS;
    data_nxt  = LCD_DATA;
    line_byte = 8'h00;
    rd_addr   = 5'd0;
    slot_last = (state == S_INIT && idx == 4'd3) ? CLR_LAST : BYTE_LAST;

    if (state == S_PWR) begin
      if (cnt == PWR_LAST) begin
        state_nxt = S_INIT;
        idx_nxt   = 4'd0;
        latch     = 1'b1;
      end
    end else if (cnt == slot_last) begin
      latch = 1'b1;
      case (state)
        S_INIT:  if (idx == 4'd3) state_nxt = S_ADDR1; else idx_nxt = idx + 4'd1;
        S_ADDR1: begin state_nxt = S_LINE1; idx_nxt = 4'd0; end
        S_LINE1: if (idx == 4'd15) state_nxt = S_ADDR2; else idx_nxt = idx + 4'd1;
        S_ADDR2: begin state_nxt = S_LINE2; idx_nxt = 4'd0; end
        S_LINE2: if (idx == 4'd15) state_nxt = S_ADDR1; else idx_nxt = idx + 4'd1;
        default: state_nxt = S_PWR;
      endcase
    end

    // Buffer read happens on the latch edge, so a same-edge write is not seen.
    rd_addr = {(state_nxt == S_LINE2), idx_nxt};
`ifdef LCD_SNAPSHOT_EN
    line_byte = shadow[rd_addr];
`else
    line_byte = mem[rd_addr];
`endif

    if (latch) begin
      cnt_nxt = '0;
      case (state_nxt)
        S_INIT: begin
          rs_nxt = 1'b0;
          case (idx_nxt[1:0])
            2'd0:    data_nxt = 8'h38;
            2'd1:    data_nxt = 8'h0C;
            2'd2:    data_nxt = 8'h06;
            default: data_nxt = 8'h01;
          endcase
        end
        S_ADDR1: begin rs_nxt = 1'b0; data_nxt = 8'h80;      end
        S_ADDR2: begin rs_nxt = 1'b0; data_nxt = 8'hC0;      end
        S_LINE1: begin rs_nxt = 1'b1; data_nxt = line_byte;  end
        S_LINE2: begin rs_nxt = 1'b1; data_nxt = line_byte;  end
        default: begin rs_nxt = 1'b0; data_nxt = 8'h00;      end
      endcase
    end

    e_nxt    = (state_nxt != S_PWR) && (cnt_nxt >= E_FIRST) && (cnt_nxt <= E_LAST);
    done_nxt = (state_nxt == S_LINE2) && (idx_nxt == 4'd15) && (cnt_nxt == BYTE_LAST);
  end

  // State, counters and registered LCD/status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_PWR;
      cnt        <= '0;
      idx        <= 4'd0;
      LCD_E      <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_DATA   <= 8'h00;
      READY      <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      LCD_E      <= e_nxt;
      LCD_RS     <= rs_nxt;
      LCD_DATA   <= data_nxt;
      READY      <= READY | (state_nxt == S_ADDR1);
      FRAME_DONE <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_text_writer
// Description : Self-checking bench for lcd_text_writer. A cycle-position model
//               derived from the byte/frame schedule predicts every output on
//               every cycle; directed tables and sequences cover the text
//               layout, write/latch collision, snapshot and mid-transfer reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_text_writer;

  localparam int P  = 2;
  localparam int W  = 4;
  localparam int PU = 10;
  localparam int CW = 20;
  localparam int BL = 3 * P + W;            // byte slot
  localparam int INIT_LEN = 4 * BL + CW;     // four init commands incl. clear wait
  localparam int FRAME = 34 * BL;
  localparam int NF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       ready, frame_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_text_writer #(
    .PHASE_CYC(P), .WAIT_CYC(W), .POWERUP_CYC(PU), .CLEAR_WAIT_CYC(CW)
  ) dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .READY(ready), .FRAME_DONE(frame_done), .LCD_E(lcd_e), .LCD_RS(lcd_rs),
    .LCD_RW(lcd_rw), .LCD_DATA(lcd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_mem [32];
  logic [7:0] m_shadow [32];
  logic       m_rs;
  logic [7:0] m_data;
  int         cyc;
  int         fd_count;
  logic [7:0] cap [NF][34];
  logic [8:0] prev_bus;
  int         hold;

  typedef struct {
    bit         we;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Position of cycle c (c=0 is the cycle whose closing edge first sees RST low).
  function automatic void pos_of(input int c, output int seg, output int f,
                                 output int j, output int t);
    int u, v;
    seg = 0; f = 0; j = 0; t = 0;
    if (c < PU) return;
    u = c - PU;
    if (u < INIT_LEN) begin
      seg = 1;
      if (u < 3 * BL) begin j = u / BL; t = u % BL; end
      else begin j = 3; t = u - 3 * BL; end
    end else begin
      seg = 2;
      v = u - INIT_LEN;
      f = v / FRAME;
      j = (v % FRAME) / BL;
      t = v % BL;
    end
  endfunction

  function automatic int cyc_of(input int f, input int j, input int t);
    return PU + INIT_LEN + f * FRAME + j * BL + t;
  endfunction

  function automatic logic [7:0] src_byte(input int a);
`ifdef LCD_SNAPSHOT_EN
    return m_shadow[a];
`else
    return m_mem[a];
`endif
  endfunction

  // {rs, data} sent for byte j of a segment
  function automatic logic [8:0] byte_of(input int seg, input int j);
    logic [7:0] init_cmds [4];
    init_cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    if (seg == 1) return {1'b0, init_cmds[j]};
    if (j == 0) return {1'b0, 8'h80};
    if (j == 17) return {1'b0, 8'hC0};
    if (j < 17) return {1'b1, src_byte(j - 1)};
    return {1'b1, src_byte(j - 2)};
  endfunction

  // One clock: drive inputs, advance model on the edge, compare at negedge.
  task automatic step(input bit r, input bit we, input logic [4:0] a, input logic [7:0] d);
    int seg, f, j, t;
    bit latched;
    logic [13:0] exp_v, act_v;
    rst = r; wr_en = we; wr_addr = a; wr_data = d;
    seg = 0; f = 0; j = 0; t = 0; latched = 0;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = 8'h20; m_shadow[i] = 8'h20; end
      m_rs = 1'b0; m_data = 8'h00; cyc = 0;
    end else begin
      cyc = cyc + 1;
      pos_of(cyc, seg, f, j, t);
      if (seg == 2 && j == 0 && t == 0)
        for (int i = 0; i < 32; i++) m_shadow[i] = m_mem[i];
      if (seg > 0 && t == 0) begin
        {m_rs, m_data} = byte_of(seg, j);
        latched = 1;
      end
      if (we) m_mem[a] = d;
    end
    @(negedge clk);
    exp_v = {(seg == 2),
             (seg == 2 && j == 33 && t == BL - 1),
             (seg > 0 && t >= P && t <= 2 * P - 1),
             m_rs, 1'b0, m_data, 1'b0};
    act_v = {ready, frame_done, lcd_e, lcd_rs, lcd_rw, lcd_data, 1'b0};
    check($sformatf("outputs cycle %0d {rdy,fd,e,rs,rw,data}", cyc), 32'(act_v), 32'(exp_v));
    if (frame_done === 1'b1) fd_count++;
    if (latched && seg == 2 && f < NF) cap[f][j] = lcd_data;
    if (r) begin
      hold = 0;
    end else begin
      if (lcd_e === 1'b1 || hold > 0)
        check($sformatf("bus stable cycle %0d", cyc), 32'({lcd_rs, lcd_data}), 32'(prev_bus));
      hold = (lcd_e === 1'b1) ? P : ((hold > 0) ? hold - 1 : 0);
    end
    prev_bus = {lcd_rs, lcd_data};
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) step(1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  // Write so that the write is sampled on the edge that opens cycle c.
  task automatic write_at(input int c, input logic [4:0] a, input logic [7:0] d);
    idle_until(c - 1);
    step(1'b0, 1'b1, a, d);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd0,  "S", "S"};
    vecs[1]  = '{1'b1, 5'd1,  "L", "L"};
    vecs[2]  = '{1'b1, 5'd2,  "O", "O"};
    vecs[3]  = '{1'b1, 5'd3,  "T", "T"};
    vecs[4]  = '{1'b1, 5'd16, "C", "C"};
    vecs[5]  = '{1'b1, 5'd17, "O", "O"};
    vecs[6]  = '{1'b1, 5'd18, "I", "I"};
    vecs[7]  = '{1'b1, 5'd19, "N", "N"};
    vecs[8]  = '{1'b1, 5'd20, " ", " "};
    vecs[9]  = '{1'b1, 5'd21, "0", "0"};
    vecs[10] = '{1'b1, 5'd22, "7", "7"};
    vecs[11] = '{1'b0, 5'd4,  8'h00, 8'h20};
    vecs[12] = '{1'b0, 5'd31, 8'h00, 8'h20};

    for (int f = 0; f < NF; f++) for (int j = 0; j < 34; j++) cap[f][j] = 8'h00;
    fd_count = 0; hold = 0; prev_bus = '0; cyc = 0;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 5'd0, 8'd0);

    // Text written during power-up, before READY
    for (int i = 0; i < 13; i++)
      if (vecs[i].we) step(1'b0, 1'b1, vecs[i].addr, vecs[i].data);

    // Frame 1: write 0x41 to addr 5 on the latch edge of addr 5 (frame byte 6)
    write_at(cyc_of(1, 6, 0), 5'd5, 8'h41);
    idle_until(cyc_of(3, 0, 0) - 1);

    // Layout of the first frame from the table
    check("frame0 addr1 cmd", 32'(cap[0][0]), 32'h80);
    check("frame0 addr2 cmd", 32'(cap[0][17]), 32'hC0);
    for (int i = 0; i < 13; i++)
      check($sformatf("frame0 char addr %0d", vecs[i].addr),
            32'(cap[0][(vecs[i].addr < 16) ? vecs[i].addr + 1 : vecs[i].addr + 2]),
            32'(vecs[i].exp));
    check("collision frame sends old", 32'(cap[1][6]), 32'h20);
    check("collision next frame new", 32'(cap[2][6]), 32'h41);
    check("frame_done pulses after 3 frames", 32'(fd_count), 32'd3);

    // Frame 3: write 0x42 to addr 20 (frame byte 22) mid-LINE1
    write_at(cyc_of(3, 8, 3), 5'd20, 8'h42);
    idle_until(cyc_of(5, 0, 0) - 1);
`ifdef LCD_SNAPSHOT_EN
    check("snapshot frame keeps old", 32'(cap[3][22]), 32'h20);
`else
    check("live frame shows new", 32'(cap[3][22]), 32'h42);
`endif
    check("next frame shows new", 32'(cap[4][22]), 32'h42);

    // Randomized writes, checked cycle by cycle against the model
    while (cyc < cyc_of(7, 0, 0) - 1) begin
      if ($urandom_range(3) == 0)
        step(1'b0, 1'b1, 5'($urandom_range(31)), 8'($urandom_range(255)));
      else
        step(1'b0, 1'b0, 5'd0, 8'd0);
    end
    check("frame_done pulses after 7 frames", 32'(fd_count), 32'd7);

    // Reset while E is high during LINE2
    idle_until(cyc_of(7, 20, P));
    check("E high before reset", 32'(lcd_e), 32'd1);
    step(1'b1, 1'b0, 5'd0, 8'd0);
    check("E after reset edge", 32'(lcd_e), 32'd0);
    check("READY after reset edge", 32'(ready), 32'd0);

    // Full re-init and one frame of spaces
    for (int f = 0; f < NF; f++) for (int j = 0; j < 34; j++) cap[f][j] = 8'h00;
    idle_until(cyc_of(1, 0, 0) - 1);
    for (int j = 1; j < 34; j++)
      if (j != 17) check($sformatf("post-reset space byte %0d", j), 32'(cap[0][j]), 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_text_writer.md
# lcd_text_writer

Character-buffered transmitter for the 2x16 HD44780-style text LCD. Game control writes characters into a 32-byte screen buffer at any time through a single-cycle write port. The block powers up and initialises the panel, then continuously refreshes both lines from the buffer, driving LCD_E/LCD_RS/LCD_RW/LCD_DATA. It replaces the fixed-message LCD generators with one writer owned by the main game FSM.

## Interface
- PHASE_CYC, 10: cycles per bus phase (setup, E-high, hold); must be ≥1
- WAIT_CYC, 100: idle cycles after each byte (command execution time); must be ≥1
- POWERUP_CYC, 15000: cycles waited after reset before the first command
- CLEAR_WAIT_CYC, 2000: extra idle cycles after the clear-display command
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- WR_EN  in  1  buffer write strobe
- WR_ADDR  in  5  char position: 0-15 = line 1 col 0-15, 16-31 = line 2
- WR_DATA  in  8  ASCII code
- READY  out  1  high once init sequence complete; stays high until RST
- FRAME_DONE  out  1  one-cycle pulse when last char of line 2 finishes its wait
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  constant 0 (write only, no busy polling)
- LCD_DATA  out  8  LCD data bus

## Operation
- Buffer: 32 x 8 bits; RST sets every entry to 0x20 (space). WR_EN writes WR_DATA at WR_ADDR on that edge; no back-pressure, writes always accepted.
- States: PWR -> INIT -> ADDR1 -> LINE1 -> ADDR2 -> LINE2 -> ADDR1 ... (refresh loops forever).
- PWR: all LCD outputs 0; wait POWERUP_CYC cycles.
- INIT: send commands 0x38 (8-bit, 2-line, 5x8), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear). After 0x01, wait WAIT_CYC + CLEAR_WAIT_CYC. READY rises on the cycle ADDR1 is first entered.
- ADDR1 sends command 0x80; LINE1 sends data bytes buffer[0..15]. ADDR2 sends 0xC0; LINE2 sends buffer[16..31].
- Byte source latched on the first setup cycle of that byte. A write to a position already latched appears on the next refresh.
- Simultaneous write and latch of the same address: the old value is sent; the new value is stored.

## Timing
- Per byte, relative to latch cycle t=0: LCD_RS/LCD_DATA valid from t=0. LCD_E=1 for t in [PHASE_CYC, 2*PHASE_CYC-1], 0 otherwise. RS/DATA held through t = 3*PHASE_CYC+WAIT_CYC-1. The next byte latches at t = 3*PHASE_CYC+WAIT_CYC. The clear command adds CLEAR_WAIT_CYC.
- RS/DATA never change while LCD_E=1 or during the hold phase.
- First command latches exactly POWERUP_CYC cycles after the cycle RST is sampled low.
- Frame = 34 bytes = 34*(3*PHASE_CYC+WAIT_CYC) cycles. FRAME_DONE pulses on the last wait cycle of byte 31; ADDR1 latches on the next cycle.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, READY=0, FRAME_DONE=0, state PWR, all counters 0.
- RST mid-transfer: on the next edge LCD_E drops to 0 immediately, READY clears, and the full power-up/init sequence repeats.
- Counters are sized for the largest parameter; no wrap occurs before the terminal count.

## Configuration
- LCD_SNAPSHOT_EN defined: a 32-byte shadow buffer is added. The whole live buffer is copied to the shadow in one cycle, on the cycle ADDR1 is entered, before its 0x80 is latched. LINE1/LINE2 read the shadow, so each frame is coherent. A write on the copy cycle lands in the live buffer only and appears next frame. Shadow resets to 0x20.
- Not defined: no shadow; bytes read from the live buffer at latch time, as described under Operation.

## Test plan
Run all tests with PHASE_CYC=2, WAIT_CYC=4, POWERUP_CYC=10, CLEAR_WAIT_CYC=20.
- Reset, then idle: outputs 0 for 10 cycles; then 0x38, 0x0C, 0x06, 0x01 with RS=0. E high 2 cycles per byte, 10-cycle byte spacing, 30-cycle gap after 0x01. READY rises, then 0x80 and sixteen 0x20 with RS=1.
- Write "SLOT" to addr 0-3 and "COIN 07" to addr 16-22 before READY: first frame shows 0x80, S L O T, 12 spaces, 0xC0, C O I N space 0 7, 9 spaces. FRAME_DONE pulses once per 340 cycles.
- Write 0x41 to addr 5 on the latch cycle of addr 5: this frame sends 0x20, next frame 0x41.
- Assert RST while LCD_E=1 in LINE2: LCD_E=0 and READY=0 on the next edge. Buffer returns to spaces; the init sequence restarts after 10 cycles.
- Checker across all runs: LCD_RW always 0, and RS/DATA stable whenever LCD_E=1 and for 2 cycles after it falls.
- With LCD_SNAPSHOT_EN: write 0x42 to addr 20 mid-LINE1. The frame still sends the old value at addr 20; the next frame sends 0x42. Without the macro the same frame sends 0x42.
